// File: rtl/adder_rr_arbiter.sv
// Shared registered adder fronted by a round-robin arbiter over N_REQ
// requesters, with a one-entry valid/ready result slot.

package my_package;
  parameter int my_width = 8;
endpackage

module adder_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = my_package::my_width,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH:0]         rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  cand;
  logic             found;
  logic             accept;
  logic             transfer;
  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];

  // Unpack the flat operand buses into per-requester arrays.
  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      a_arr[k] = req_a[k*WIDTH +: WIDTH];
      b_arr[k] = req_b[k*WIDTH +: WIDTH];
    end
  end

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ID_W'((32'(ptr) + k) % 32'(N_REQ));
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign accept   = !rsp_valid || rsp_ready;
  assign transfer = !reset && accept && found;
  assign busy     = rsp_valid || (|req_valid);

  // One-hot ready to the granted requester only when the slot can take a result.
  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[grant] = 1'b1;
  end

  // Result slot and pointer; pointer moves only on a transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      ptr       <= '0;
    end else if (transfer) begin
      rsp_valid <= 1'b1;
      rsp_data  <= {1'b0, a_arr[grant]} + {1'b0, b_arr[grant]};
      rsp_id    <= grant;
      ptr       <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter: behavioural model checked every
// cycle on the falling edge, plus directed literal expectations.

module tb_adder_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W:0]     rsp_data;
  logic [IW-1:0]  rsp_id;
  logic           busy;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  // Model state: what the result slot and the fairness pointer must hold.
  bit m_valid = 1'b0;
  int m_data  = 0;
  int m_id    = 0;
  int m_ptr   = 0;

  adder_rr_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int op_a(input int i);
    logic [N*W-1:0] v;
    v = req_a;
    return int'(v[i*W +: W]);
  endfunction

  function automatic int op_b(input int i);
    logic [N*W-1:0] v;
    v = req_b;
    return int'(v[i*W +: W]);
  endfunction

  // Per-cycle compare against the model, then advance the model across the next edge.
  always @(negedge clock) begin
    if (checking) begin
      logic [N-1:0] exp_ready;
      bit g_found;
      int g;
      exp_ready = '0;
      g_found   = 1'b0;
      g         = 0;
      if (!reset && (!m_valid || rsp_ready)) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (!g_found && req_valid[i]) begin
            g_found = 1'b1;
            g       = i;
          end
        end
        if (g_found) exp_ready[g] = 1'b1;
      end
      chk("model_req_ready", 32'(req_ready), 32'(exp_ready));
      chk("model_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("model_rsp_data",  32'(rsp_data),  32'(m_data));
      chk("model_rsp_id",    32'(rsp_id),    32'(m_id));
      chk("model_busy",      32'(busy),      32'(m_valid || (req_valid != 0)));
      if (reset) begin
        m_valid = 1'b0; m_data = 0; m_id = 0; m_ptr = 0;
      end else if (g_found) begin
        m_valid = 1'b1;
        m_data  = op_a(g) + op_b(g);
        m_id    = g;
        m_ptr   = (g + 1) % N;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b1; req_a = '0; req_b = '0;
    cyc();
    checking = 1'b1;
    cyc();
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data",  32'(rsp_data),  32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);

    // Single requester 2.
    reset = 1'b0;
    set_op(2, 8'h10, 8'h05);
    req_valid = 4'b0100;
    #1 chk("single_ready", 32'(req_ready), 32'b0100);
    cyc();
    req_valid = '0;
    #1;
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_data",  32'(rsp_data),  32'h015);
    chk("single_id",    32'(rsp_id),    32'd2);
    chk("single_ready_off", 32'(req_ready), 32'd0);

    // Carry out of the operand width; ptr=3 so search wraps to requester 0.
    set_op(0, 8'hFF, 8'h01);
    req_valid = 4'b0001;
    #1 chk("carry_ready", 32'(req_ready), 32'b0001);
    cyc();
    set_op(0, 8'hFF, 8'hFF);
    #1;
    chk("carry_data1", 32'(rsp_data), 32'h100);
    chk("carry_ready2", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = '0;
    #1 chk("carry_data2", 32'(rsp_data), 32'h1FE);
    cyc();

    // All requesters valid from a reset pointer: strict rotation.
    for (int i = 0; i < N; i++) set_op(i, 8'(8'h30 + i*16), 8'(8'hE0 + i));
    do_reset();
    req_valid = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1 << (j % N)));
      if (j > 0) chk("rr_id", 32'(rsp_id), 32'((j - 1) % N));
      cyc();
    end

    // Backpressure after the first result from a fresh pointer.
    do_reset();
    req_valid = 4'b1111;
    cyc();
    rsp_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_id",    32'(rsp_id),    32'd0);
      chk("bp_data",  32'(rsp_data),  32'h110);
      if (j < 2) cyc();
    end
    cyc();
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'b0010);
    cyc();
    #1 chk("bp_after_id", 32'(rsp_id), 32'd1);
    chk("bp_next_ready", 32'(req_ready), 32'b0100);
    cyc();
    #1 chk("bp_ready3", 32'(req_ready), 32'b1000);
    cyc();

    // Pointer wrapped to 0: requesters 1 and 3 only.
    req_valid = 4'b1010;
    #1 chk("sparse_first", 32'(req_ready), 32'b0010);
    cyc();
    #1 chk("sparse_second", 32'(req_ready), 32'b1000);
    cyc();
    #1 chk("sparse_id", 32'(rsp_id), 32'd3);

    // Reset with a pending result for requester 0.
    req_valid = 4'b0001;
    cyc();
    req_valid = '0;
    rsp_ready = 1'b0;
    #1 chk("pend_id", 32'(rsp_id), 32'd0);
    chk("pend_valid", 32'(rsp_valid), 32'd1);
    cyc();
    reset = 1'b1;
    req_valid = 4'b1111;
    #1 chk("rst_ready_blocked", 32'(req_ready), 32'd0);
    cyc();
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_data",  32'(rsp_data),  32'd0);
    chk("post_rst_id",    32'(rsp_id),    32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'b0001);
    cyc();

    // Requester withdraws without a transfer; slot drains and goes idle.
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    cyc();
    req_valid = '0;
    cyc();
    rsp_ready = 1'b1;
    cyc();
    #1 chk("idle_busy", 32'(busy), 32'd0);
    cyc();
    cyc();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
